// File: rtl/tdm_slot_sequencer.sv
// Frame aligner for a 4-slot TDM stream: hunts for fsync, confirms spacing, flywheels over misses.
// One cycle din->out latency; no backpressure, one bit is consumed every cycle.
module tdm_slot_sequencer #(
  parameter int SLOT_LEN = 4,
  parameter int LOCK_CNT = 2,
  parameter int LOSS_CNT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic       fsync,
  output logic       out,
  output logic       s0,
  output logic       s1,
  output logic       locked,
  output logic       slot_start,
  output logic       frame_err,
  output logic [7:0] err_cnt
);

  localparam int BW = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
  localparam logic [BW-1:0] LAST   = BW'(SLOT_LEN - 1);
  // Position immediately after slot 0 / bit 0 (differs when a slot is a single bit)
  localparam logic [BW-1:0] POS1_B = (SLOT_LEN == 1) ? '0 : BW'(1);
  localparam logic [1:0]    POS1_S = (SLOT_LEN == 1) ? 2'd1 : 2'd0;

  typedef enum logic [1:0] {HUNT, CHECK, LOCKED, HOLD} state_t;

  state_t         state, state_n;
  logic [BW-1:0]  bcnt, bcnt_n, bcnt_adv;
  logic [1:0]     slot, slot_n, slot_adv;
  logic [3:0]     good, good_n, miss, miss_n;
  logic           err, boundary, fwd;

  assign boundary = (bcnt == '0) && (slot == 2'd0);

  always_comb begin
    bcnt_adv = bcnt + BW'(1);
    slot_adv = slot;
    if (bcnt == LAST) begin
      bcnt_adv = '0;
      slot_adv = slot + 2'd1;
    end
  end

  always_comb begin
    state_n = state;
    bcnt_n  = bcnt_adv;
    slot_n  = slot_adv;
    good_n  = good;
    miss_n  = miss;
    err     = 1'b0;
    case (state)
      HUNT: begin
        bcnt_n = '0;
        slot_n = 2'd0;
        if (fsync) begin
          bcnt_n  = POS1_B;
          slot_n  = POS1_S;
          good_n  = 4'd1;
          state_n = (LOCK_CNT == 1) ? LOCKED : CHECK;
        end
      end
      CHECK: begin
        if (boundary && fsync) begin
          good_n = good + 4'd1;
          if (good_n >= 4'(LOCK_CNT)) state_n = LOCKED;
        end else if (boundary) begin
          err     = 1'b1;
          state_n = HUNT;
          bcnt_n  = '0;
          slot_n  = 2'd0;
        end else if (fsync) begin
          // Treat this sync as the true frame start and restart confirmation
          err    = 1'b1;
          good_n = 4'd1;
          bcnt_n = POS1_B;
          slot_n = POS1_S;
        end
      end
      LOCKED, HOLD: begin
        if (boundary && fsync) begin
          miss_n  = 4'd0;
          state_n = LOCKED;
        end else if (boundary) begin
          err    = 1'b1;
          miss_n = (state == LOCKED) ? 4'd1 : miss + 4'd1;
          if (miss_n >= 4'(LOSS_CNT)) begin
            state_n = HUNT;
            bcnt_n  = '0;
            slot_n  = 2'd0;
          end else begin
            state_n = HOLD;
          end
        end else if (fsync) begin
          err = 1'b1;
        end
      end
      default: state_n = HUNT;
    endcase
  end

  assign fwd    = (state_n == LOCKED) || (state_n == HOLD);
  assign locked = (state == LOCKED) || (state == HOLD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= HUNT;
      bcnt       <= '0;
      slot       <= 2'd0;
      good       <= 4'd0;
      miss       <= 4'd0;
      out        <= 1'b0;
      s0         <= 1'b0;
      s1         <= 1'b0;
      slot_start <= 1'b0;
      frame_err  <= 1'b0;
      err_cnt    <= 8'd0;
    end else begin
      state      <= state_n;
      bcnt       <= bcnt_n;
      slot       <= slot_n;
      good       <= good_n;
      miss       <= miss_n;
      out        <= fwd & din;
      s0         <= fwd & slot[1];
      s1         <= fwd & slot[0];
      slot_start <= fwd && (bcnt == '0);
      frame_err  <= err;
      if (err && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_tdm_slot_sequencer.sv
// Randomised bench: a frame-position reference model predicts every output cycle into a queue.
module tb_tdm_slot_sequencer;

  localparam int SLOT_LEN = 4;
  localparam int LOCK_CNT = 2;
  localparam int LOSS_CNT = 2;
  localparam int FR       = 4 * SLOT_LEN;

  typedef struct packed {
    logic       o;
    logic [1:0] sl;
    logic       lk;
    logic       ss;
    logic       fe;
    logic [7:0] ec;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din = 1'b0;
  logic       fsync = 1'b0;
  logic       out, s0, s1, locked, slot_start, frame_err;
  logic [7:0] err_cnt;

  tdm_slot_sequencer #(.SLOT_LEN(SLOT_LEN), .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT)) dut (
    .clk(clk), .rst(rst), .din(din), .fsync(fsync), .out(out), .s0(s0), .s1(s1),
    .locked(locked), .slot_start(slot_start), .frame_err(frame_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Model: mode 0 searching, 1 confirming, 2 in lock, 3 coasting; pos = cycle offset in frame
  int m_mode, m_pos, m_good, m_miss, m_errs;

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_good = 0; m_miss = 0; m_errs = 0;
  endtask

  task automatic model_step(input logic d, input logic f, output exp_t e);
    int  at, nmode, npos;
    bit  er, fw;
    at = m_pos; nmode = m_mode; npos = (at + 1) % FR; er = 0;
    case (m_mode)
      0: begin
        npos = 0;
        if (f) begin
          npos = 1; m_good = 1;
          nmode = (LOCK_CNT == 1) ? 2 : 1;
        end
      end
      1: begin
        if (f && at == 0) begin
          m_good++;
          if (m_good >= LOCK_CNT) nmode = 2;
        end else if (at == 0) begin
          er = 1; nmode = 0; npos = 0;
        end else if (f) begin
          er = 1; m_good = 1; npos = 1;
        end
      end
      default: begin
        if (f && at == 0) begin
          m_miss = 0; nmode = 2;
        end else if (at == 0) begin
          er = 1;
          m_miss = (m_mode == 2) ? 1 : m_miss + 1;
          if (m_miss >= LOSS_CNT) begin nmode = 0; npos = 0; end
          else nmode = 3;
        end else if (f) begin
          er = 1;
        end
      end
    endcase
    fw = (nmode >= 2);
    if (er && m_errs < 255) m_errs++;
    e.o  = fw & d;
    e.sl = fw ? 2'(at / SLOT_LEN) : 2'd0;
    e.lk = fw;
    e.ss = fw && (at % SLOT_LEN == 0);
    e.fe = er;
    e.ec = 8'(m_errs);
    m_mode = nmode; m_pos = npos;
  endtask

  task automatic apply(input logic d, input logic f);
    exp_t e;
    din = d; fsync = f;
    model_step(d, f, e);
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic d, input logic f);
    @(negedge clk);
    apply(d, f);
  endtask

  // Monitor: outputs are presented every cycle, checked just after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({out, s0, s1, locked, slot_start, frame_err, err_cnt} !== e) begin
          n_fail++;
          $display("FAIL cycle_out t=%0t got out=%b sel=%b%b locked=%b ss=%b ferr=%b ecnt=%0d expected out=%b sel=%b locked=%b ss=%b ferr=%b ecnt=%0d",
                   $time, out, s0, s1, locked, slot_start, frame_err, err_cnt,
                   e.o, e.sl, e.lk, e.ss, e.fe, e.ec);
        end
      end
    end
  end

  task automatic check_zero(input string name);
    n_checks++;
    if ({out, s0, s1, locked, slot_start, frame_err, err_cnt} !== 14'd0) begin
      n_fail++;
      $display("FAIL %s got out=%b sel=%b%b locked=%b ss=%b ferr=%b ecnt=%0d expected all zero",
               name, out, s0, s1, locked, slot_start, frame_err, err_cnt);
    end
  endtask

  initial begin
    logic [15:0] pat;
    pat = 16'hA5A5;
    model_reset();
    #1;
    check_zero("reset_initial");
    @(negedge clk);
    rst = 1'b0;
    apply(pat[15], 1'b1);

    // Clean acquisition with A5A5 data
    for (int t = 1; t < 6 * FR; t++) drive(pat[15 - (t % 16)], (t % FR) == 0);

    // Random drops and stray syncs around a periodic frame
    for (int t = 0; t < 40 * FR; t++)
      drive(1'($urandom), (t % FR == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 39) == 0));

    // Relock, then asynchronous reset in the middle of a frame
    for (int t = 0; t < 4 * FR + 5; t++) drive(1'($urandom), (t % FR) == 0);
    @(negedge clk);
    #2 rst = 1'b1;
    din = 1'b0; fsync = 1'b0;
    #1;
    check_zero("reset_async");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    apply(1'b1, 1'b1);
    for (int t = 1; t < 4 * FR; t++) drive(1'($urandom), (t % FR) == 0);

    // Two consecutive missing syncs drop lock
    for (int t = 0; t < 6 * FR; t++) drive(1'($urandom), (t % FR == 0) && (t / FR != 1) && (t / FR != 2));

    // Lock lost for good, then a misaligned second sync during confirmation
    for (int t = 0; t < 3 * FR; t++) drive(1'($urandom), 1'b0);
    drive(1'($urandom), 1'b1);
    for (int t = 1; t < 7; t++) drive(1'($urandom), 1'b0);
    for (int t = 0; t < 3 * FR; t++) drive(1'($urandom), (t % FR) == 0);

    // Continuous sync: an error every cycle while confirming, drives the counter to saturation
    for (int t = 0; t < 300; t++) drive(1'($urandom), 1'b1);

    // Sparse random syncs
    for (int t = 0; t < 500; t++) drive(1'($urandom), $urandom_range(0, 7) == 0);

    drive(1'b0, 1'b0);
    @(posedge clk);
    #3;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
